// File: rtl/mod_counter_ctrl.sv
// Modulo-N counter controller: programmable modulus, one-shot/free-run, start/pause/resume/abort.
// Optional prescaler on the count step is enabled by defining MODCTRL_PRESCALE_EN.
module mod_counter_ctrl #(
    parameter int WIDTH       = 4,
    parameter int DEFAULT_MOD = 5
`ifdef MODCTRL_PRESCALE_EN
    ,
    parameter int DIV_W       = 4
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_mod,
    input  logic             cfg_oneshot,
`ifdef MODCTRL_PRESCALE_EN
    input  logic [DIV_W-1:0] cfg_div,
`endif
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    // state   | meaning
    // S_IDLE  | stopped, count 0, config accepted
    // S_RUN   | counting one value per step
    // S_PAUSE | count held, waiting for resume (start) or abort (stop)
    // S_DONE  | one-shot cycle finished, done held, config accepted
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] mod_q;
    logic [WIDTH-1:0] mod_last;
    logic             oneshot_q;
    logic             done_q, done_d;
    logic             cfg_take;
    logic             at_last;
    logic             step;
    logic             pre_clr;

    // A modulus of 0 wraps to all-ones here, which gives the 2**WIDTH count for free.
    assign mod_last  = mod_q - WIDTH'(1);
    assign at_last   = (count_q == mod_last);
    assign cfg_ready = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign cfg_take  = cfg_valid && cfg_ready;
    assign tc        = (state_q == S_RUN) && step && at_last;
    assign count     = count_q;
    assign done      = done_q;

`ifdef MODCTRL_PRESCALE_EN
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] pre_cnt;

    assign step = (pre_cnt == div_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else if (pre_clr || state_q != S_RUN || step) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else if (cfg_take) begin
            div_q <= cfg_div;
        end
    end
`else
    assign step = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = done_q;
        pre_clr = 1'b0;
        if (cfg_take) begin
            done_d = 1'b0;
        end
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    count_d = '0;
                    done_d  = 1'b0;
                    pre_clr = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    // A terminal step coinciding with stop still wraps before pausing.
                    state_d = S_PAUSE;
                    pre_clr = 1'b1;
                    if (tc) begin
                        count_d = '0;
                    end
                end else if (step) begin
                    if (at_last) begin
                        count_d = '0;
                        if (oneshot_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (start) begin
                    state_d = S_RUN;
                    pre_clr = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mod_q     <= WIDTH'(DEFAULT_MOD);
            oneshot_q <= 1'b0;
        end else if (cfg_take) begin
            mod_q     <= cfg_mod;
            oneshot_q <= cfg_oneshot;
        end
    end

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Self-checking bench for mod_counter_ctrl: directed scenarios plus random traffic
// compared every cycle against a flag/arithmetic model of the controller.
module tb_mod_counter_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [3:0] cfg_mod = 4'd0;
    logic       cfg_oneshot = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] count;
    logic       tc;
    logic       busy;
    logic       done;
`ifdef MODCTRL_PRESCALE_EN
    logic [3:0] cfg_div = 4'd0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // Model: run/pause flags, integer count, effective modulus 1..16, RUN-cycle phase.
    bit m_run, m_pause, m_oneshot, m_done;
    int m_count, m_mod, m_div, m_phase;

    mod_counter_ctrl #(.WIDTH(4), .DEFAULT_MOD(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_mod     (cfg_mod),
        .cfg_oneshot (cfg_oneshot),
`ifdef MODCTRL_PRESCALE_EN
        .cfg_div     (cfg_div),
`endif
        .start       (start),
        .stop        (stop),
        .count       (count),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic bit m_step();
        return (m_phase % (m_div + 1)) == m_div;
    endfunction

    function automatic bit m_tc();
        return m_run && m_step() && (m_count == m_mod - 1);
    endfunction

    task automatic model_reset();
        m_run = 0; m_pause = 0; m_oneshot = 0; m_done = 0;
        m_count = 0; m_mod = 5; m_div = 0; m_phase = 0;
    endtask

    task automatic model_edge(input bit st, input bit sp, input bit cv, input int cm, input bit co);
        bit stp;
        bit term;
        stp  = m_step();
        term = (m_count == m_mod - 1);
        if (!m_run && !m_pause) begin
            if (cv) begin
                m_mod = (cm == 0) ? 16 : cm;
                m_oneshot = co;
                m_done = 0;
`ifdef MODCTRL_PRESCALE_EN
                m_div = int'(cfg_div);
`endif
            end
            if (st) begin
                m_run = 1; m_count = 0; m_done = 0; m_phase = 0;
            end
        end else if (m_run) begin
            if (sp) begin
                m_run = 0; m_pause = 1; m_phase = 0;
                if (stp && term) m_count = 0;
            end else begin
                m_phase++;
                if (stp) begin
                    m_count = (m_count + 1) % m_mod;
                    if (term && m_oneshot) begin
                        m_run = 0; m_done = 1;
                    end
                end
            end
        end else begin
            if (sp) begin
                m_pause = 0; m_count = 0;
            end else if (st) begin
                m_pause = 0; m_run = 1; m_phase = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, compare all outputs to the model, then clock.
    task automatic cyc(input bit st, input bit sp, input bit cv, input int cm, input bit co);
        start = st; stop = sp; cfg_valid = cv; cfg_mod = 4'(cm); cfg_oneshot = co;
        #1;
        chk("count", int'(count), m_count);
        chk("tc", int'(tc), int'(m_tc()));
        chk("busy", int'(busy), int'(m_run || m_pause));
        chk("cfg_ready", int'(cfg_ready), int'(!(m_run || m_pause)));
        chk("done", int'(done), int'(m_done));
        @(posedge clock);
        model_edge(st, sp, cv, cm, co);
        @(negedge clock);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        int tc_seen;
        model_reset();
        #2;
        chk("rst_count", int'(count), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tc", int'(tc), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Default MOD-5 free run: tc on the 5th and 10th RUN cycles.
        cyc(1, 0, 0, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            chk("s1_count", int'(count), (i - 1) % 5);
            chk("s1_tc", int'(tc), int'(i == 5 || i == 10));
            cyc(0, 0, 0, 0, 0);
        end
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);

        // One-shot MOD-3.
        cyc(0, 0, 1, 3, 1);
        cyc(1, 0, 0, 0, 0);
        tc_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tc_seen += int'(tc);
            cyc(0, 0, 0, 0, 0);
        end
        chk("s2_tc_once", tc_seen, 1);
        chk("s2_done", int'(done), 1);
        chk("s2_count", int'(count), 0);
        chk("s2_busy", int'(busy), 0);

        // Pause / resume / abort.
        cyc(0, 0, 1, 5, 0);
        cyc(1, 0, 0, 0, 0);
        idle_cycles(2);
        cyc(0, 1, 0, 0, 0);
        idle_cycles(2);
        chk("s3_hold", int'(count), 2);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("s3_resume", int'(count), 3);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("s3_abort", int'(count), 0);

        // cfg ignored while running; start&&stop pauses; modulus 0 wraps at 15.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 7, 1);
        idle_cycles(8);
        cyc(1, 1, 0, 0, 0);
        chk("s4_paused", int'(busy), 1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        idle_cycles(18);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);

        // Async reset mid-run at count 3.
        cyc(0, 0, 1, 5, 1);
        cyc(1, 0, 0, 0, 0);
        idle_cycles(3);
        chk("s5_pre", int'(count), 3);
        cyc(0, 0, 1, 9, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("s5_count", int'(count), 0);
        chk("s5_cfg_ready", int'(cfg_ready), 1);
        chk("s5_busy", int'(busy), 0);
        model_reset();
        start = 0; stop = 0; cfg_valid = 0;
        @(negedge clock);
        reset = 1'b1;
        cyc(1, 0, 0, 0, 0);
        idle_cycles(7);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);

`ifdef MODCTRL_PRESCALE_EN
        // Prescale by 3 with MOD-4: tc spans exactly one clock per wrap.
        cfg_div = 4'd2;
        cyc(0, 0, 1, 4, 0);
        cyc(1, 0, 0, 0, 0);
        tc_seen = 0;
        for (int i = 0; i < 24; i++) begin
            tc_seen += int'(tc);
            cyc(0, 0, 0, 0, 0);
        end
        chk("pre_tc_count", tc_seen, 2);
        cyc(0, 1, 0, 0, 0);
        idle_cycles(2);
        cyc(1, 0, 0, 0, 0);
        idle_cycles(7);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
`endif

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            bit st, sp, cv, co;
            int cm;
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 9) == 0);
            cv = ($urandom_range(0, 5) == 0);
            co = ($urandom_range(0, 2) == 0);
            cm = int'($urandom_range(0, 15));
`ifdef MODCTRL_PRESCALE_EN
            if (cv) cfg_div = 4'($urandom_range(0, 3));
`endif
            cyc(st, sp, cv, cm, co);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
